// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
package life_pkg;

    // Board geometry; the scan watchdog limit is derived from the cell count.
    localparam int unsigned ROWS      = 256;
    localparam int unsigned COLS      = 256;
    localparam int unsigned CELLS     = ROWS * COLS;
    localparam int unsigned WD_MARGIN = 4464;

    localparam int unsigned GEN_W_DEF    = 16;
    localparam int unsigned WD_W_DEF     = 18;
    localparam int unsigned WD_LIMIT_DEF = CELLS + WD_MARGIN;

    // Sequencer states; encodings are fixed so debug probes can decode them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SCAN    = 3'd2,
        ST_WAIT_VS = 3'd3,
        ST_SWAP    = 3'd4
    } state_e;

endpackage : life_pkg

// File: rtl/life_gen_sequencer_if.sv
// Control/status bundle between user controls, traverser and the sequencer.
interface life_gen_sequencer_if
    import life_pkg::*;
#(
    parameter int unsigned GEN_W = GEN_W_DEF
);

    // Requests and datapath status into the sequencer
    logic             run;
    logic             step;
    logic             tick;
    logic             vsync;
    logic             clr;
    logic             trav_finish;

    // Sequencer controls and status out
    logic             trav_rst;
    logic             trav_en;
    logic             buf_sel;
    logic [GEN_W-1:0] gen_count;
    logic             gen_done;
    logic             busy;
    logic             overrun;
    logic             timeout;

    // Environment side: drives requests, observes status
    modport master (
        output run, step, tick, vsync, clr, trav_finish,
        input  trav_rst, trav_en, buf_sel, gen_count, gen_done, busy, overrun, timeout
    );

    // Sequencer side
    modport slave (
        input  run, step, tick, vsync, clr, trav_finish,
        output trav_rst, trav_en, buf_sel, gen_count, gen_done, busy, overrun, timeout
    );

endinterface : life_gen_sequencer_if

// File: rtl/life_watchdog.sv
// Loadable up-counter with clear, enable and a registered terminal-count flag.
module life_watchdog #(
    parameter int unsigned WD_W  = 18,
    parameter int unsigned LIMIT = 70000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            load_i,
    input  logic [WD_W-1:0] load_val_i,
    output logic            tc_o
);

    localparam logic [WD_W-1:0] TC_VAL = WD_W'(LIMIT - 1);

    logic [WD_W-1:0] count_q, count_d;
    logic            tc_q;

    // Next count: clear beats load beats increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + WD_W'(1);
        end
    end

    // Counter and terminal flag; tc tracks the value held in count_q
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= (count_d == TC_VAL);
        end
    end

    assign tc_o = tc_q;

endmodule : life_watchdog

// File: rtl/life_gen_sequencer.sv
// Generation scheduler: starts generations, sequences one traverser scan,
// and commits the new board by flipping the display bank on vsync.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int unsigned GEN_W    = GEN_W_DEF,
    parameter int unsigned WD_W     = WD_W_DEF,
    parameter int unsigned WD_LIMIT = WD_LIMIT_DEF
) (
    input logic                 clk,
    input logic                 rst,
    life_gen_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic             step_pend_q, step_pend_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             buf_sel_q, buf_sel_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic             trav_rst_q, trav_rst_d;
    logic             trav_en_q, trav_en_d;
    logic             gen_done_q, gen_done_d;
    logic             busy_q, busy_d;

    logic             start_req;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_tc;

    // Scan watchdog: zeroed in START, counts every SCAN cycle
    assign wd_clr = (state_q == ST_START) || bus.clr;
    assign wd_en  = (state_q == ST_SCAN);

    life_watchdog #(
        .WD_W  (WD_W),
        .LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (wd_clr),
        .en_i       (wd_en),
        .load_i     (1'b0),
        .load_val_i ({WD_W{1'b0}}),
        .tc_o       (wd_tc)
    );

    assign start_req = step_pend_q || bus.step || (bus.run && bus.tick);

    // Next state, request latching and next values of all registered outputs
    always_comb begin
        state_d     = state_q;
        step_pend_d = step_pend_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        buf_sel_d   = buf_sel_q;
        gen_count_d = gen_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d     = ST_START;
                    step_pend_d = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                // A finish in the watchdog's last cycle still counts as a finish
                if (bus.trav_finish) begin
                    state_d = ST_WAIT_VS;
                end else if (wd_tc) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_WAIT_VS: begin
                // Bank flip and count land together with entry into SWAP
                if (bus.vsync) begin
                    state_d     = ST_SWAP;
                    buf_sel_d   = ~buf_sel_q;
                    gen_count_d = gen_count_q + GEN_W'(1);
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Requests arriving mid-generation: ticks are dropped, one step is kept
        if (state_q != ST_IDLE) begin
            if (bus.tick) begin
                overrun_d = 1'b1;
            end
            if (bus.step) begin
                step_pend_d = 1'b1;
            end
        end

        // Clear aborts everything and returns the board state to generation zero
        if (bus.clr) begin
            state_d     = ST_IDLE;
            step_pend_d = 1'b0;
            overrun_d   = 1'b0;
            timeout_d   = 1'b0;
            buf_sel_d   = 1'b0;
            gen_count_d = '0;
        end

        trav_rst_d = (state_d == ST_START) || bus.clr;
        trav_en_d  = (state_d == ST_SCAN);
        gen_done_d = (state_d == ST_SWAP);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            buf_sel_q   <= 1'b0;
            gen_count_q <= '0;
            trav_rst_q  <= 1'b0;
            trav_en_q   <= 1'b0;
            gen_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_pend_q <= step_pend_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            buf_sel_q   <= buf_sel_d;
            gen_count_q <= gen_count_d;
            trav_rst_q  <= trav_rst_d;
            trav_en_q   <= trav_en_d;
            gen_done_q  <= gen_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.trav_rst  = trav_rst_q;
    assign bus.trav_en   = trav_en_q;
    assign bus.buf_sel   = buf_sel_q;
    assign bus.gen_count = gen_count_q;
    assign bus.gen_done  = gen_done_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.timeout   = timeout_q;

endmodule : life_gen_sequencer
